sha_farm_sched: RTL
===================

# sha_farm_sched

Scheduler sitting directly upstream of the SHA farm. It accepts a stream of 16-bit job words and writes them unit by unit into the farm's row/column grid. It then waits for the farm to go idle, reads one result word back from every unit, and streams the results downstream tagged with their row/column. One load/compute/unload pass per batch, repeated indefinitely.

## Interface
Parameters:
- WIDTH_ADD, 5, width of row/column address fields
- WIDTH_FARM, 16, farm data word width
- ROWS, 4, farm rows in use (1..2^WIDTH_ADD)
- COLS, 4, farm columns in use (1..2^WIDTH_ADD)
- WORDS, 4, job words written per unit (>=1)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- job_valid_i  in  1  job word available
- job_data_i  in  WIDTH_FARM  job word
- job_ready_o  out  1  scheduler accepts job word this cycle
- writerow_o  out  WIDTH_ADD  farm write row address
- writecol_o  out  WIDTH_ADD  farm write column address
- readrow_o  out  WIDTH_ADD  farm read row address
- readcol_o  out  WIDTH_ADD  farm read column address
- farmdata_o  out  WIDTH_FARM  word driven toward the farm bus
- farmdata_oe_o  out  1  farm bus drive enable; high = write strobe
- farmdata_i  in  WIDTH_FARM  word read from the farm bus
- farmbusy_i  in  1  farm computing
- result_valid_o  out  1  result word held for downstream
- result_data_o  out  WIDTH_FARM  result word
- result_row_o  out  WIDTH_ADD  source unit row
- result_col_o  out  WIDTH_ADD  source unit column
- result_ready_i  in  1  downstream accepts result

## Operation
- States: IDLE, LOAD, WAIT, RADDR, RCAP, RESULT.
- IDLE: entered on reset; moves to LOAD the next cycle unconditionally.
- LOAD:
  - job_ready_o=1. Each handshake (job_valid_i & job_ready_o) writes that word to the current unit (row r, col c).
  - A word counter 0..WORDS-1 advances per handshake. On wrap, c increments. On c wrap (COLS-1→0), r increments.
  - After word WORDS-1 of unit (ROWS-1, COLS-1), go to WAIT with r=c=0.
  - A stalled cycle (no handshake) issues no write.
  - farmbusy_i is ignored in LOAD.
- WAIT: job_ready_o=0. Go to RADDR on the first cycle farmbusy_i is sampled 0, but not earlier than the second cycle in WAIT (one guard cycle so the farm can raise busy).
- RADDR: drive readrow_o/readcol_o = (r,c) for one cycle, then go to RCAP.
- RCAP: capture farmdata_i into result_data_o with result_row_o/result_col_o = (r,c), set result_valid_o, then go to RESULT.
- RESULT:
  - Hold all result outputs until result_ready_i=1 while result_valid_o=1.
  - On that handshake, clear result_valid_o and advance (c, then r) in row-major order.
  - If (r,c) was the last unit, go to LOAD for the next batch with r=c=word=0; otherwise go to RADDR.
- Address and data outputs retain their last value when unused; only farmdata_oe_o qualifies writes.

## Timing
- Reset (async, immediate) values: state IDLE, all counters 0, job_ready_o=0, farmdata_oe_o=0, result_valid_o=0, every address and data output 0.
- job_ready_o is decoded from the state register. The first possible handshake is the 2nd rising edge after rst_i falls.
- Write latency 1:
  - A handshake at edge N drives farmdata_o=word, writerow_o/writecol_o=unit, farmdata_oe_o=1 during cycle N..N+1.
  - farmdata_oe_o=0 in any cycle not following a handshake.
  - Back-to-back handshakes give continuous oe.
- Read timing: read address is registered on entry to RADDR. The farm returns data one cycle later; it is sampled at the RADDR→RCAP edge. Per unit: RADDR (1) + RCAP (1) + RESULT (>=1) cycles. With result_ready_i tied 1, this is 3 cycles per unit.
- No unit is skipped or repeated under any job_valid_i / result_ready_i stall pattern.
- rst_i asserted mid-batch: outputs take reset values asynchronously and the partial batch is discarded. There is no resumption.

## Test plan
- ROWS=COLS=2, WORDS=2, job_valid_i held 1, words 0x0001..0x0008: oe pulses for 8 consecutive cycles. (row,col) sequence is (0,0)(0,0)(0,1)(0,1)(1,0)(1,0)(1,1)(1,1), data 0x0001..0x0008; job_ready_o falls after the 8th handshake.
- Same config, job_valid_i toggling 1/0 each cycle: identical write sequence with oe gaps on the stall cycles, and no extra writes.
- farmbusy_i held 1 for 20 cycles after load: readrow_o/readcol_o stay unchanged until busy falls. The first RADDR is (0,0) one cycle after busy is sampled 0.
- Farm model returning 0xA000+row*16+col, result_ready_i=1: results 0xA000, 0xA001, 0xA010, 0xA011 with matching row/col tags, one every 3 cycles, then job_ready_o=1.
- result_ready_i held 0 for 10 cycles on the 2nd result: result_data_o=0xA001 and result_valid_o stay stable for all 10 cycles. No address change occurs until the handshake.
- rst_i pulsed during the 5th write: oe drops to 0 in the same cycle and job_ready_o=0. After release, the next accepted word is written to (0,0).

Source files
------------

// File: rtl/sha_farm_sched.sv
// sha_farm_sched: loads job words into the SHA farm grid, waits for idle,
// then reads one result per unit back and streams it out tagged with row/col.
module sha_farm_sched #(
    parameter int WIDTH_ADD  = 5,
    parameter int WIDTH_FARM = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int WORDS      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  job_valid_i,
    input  logic [WIDTH_FARM-1:0] job_data_i,
    output logic                  job_ready_o,
    output logic [WIDTH_ADD-1:0]  writerow_o,
    output logic [WIDTH_ADD-1:0]  writecol_o,
    output logic [WIDTH_ADD-1:0]  readrow_o,
    output logic [WIDTH_ADD-1:0]  readcol_o,
    output logic [WIDTH_FARM-1:0] farmdata_o,
    output logic                  farmdata_oe_o,
    input  logic [WIDTH_FARM-1:0] farmdata_i,
    input  logic                  farmbusy_i,
    output logic                  result_valid_o,
    output logic [WIDTH_FARM-1:0] result_data_o,
    output logic [WIDTH_ADD-1:0]  result_row_o,
    output logic [WIDTH_ADD-1:0]  result_col_o,
    input  logic                  result_ready_i
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RADDR, S_RCAP, S_RESULT} state_t;

    localparam int WW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [WW-1:0]        W_LAST = WW'(WORDS - 1);
    localparam logic [WIDTH_ADD-1:0] R_LAST = WIDTH_ADD'(ROWS - 1);
    localparam logic [WIDTH_ADD-1:0] C_LAST = WIDTH_ADD'(COLS - 1);

    state_t                r_state, w_state_nxt;
    logic [WW-1:0]         r_word;
    logic [WIDTH_ADD-1:0]  r_row, r_col, r_wrow, r_wcol, r_rrow, r_rcol, r_res_row, r_res_col;
    logic [WIDTH_FARM-1:0] r_fdata, r_res_data;
    logic                  r_oe, r_res_valid, r_guard;
    logic                  w_hs, w_word_last, w_col_last, w_row_last, w_unit_last;
    logic [WIDTH_ADD-1:0]  w_col_nxt, w_row_nxt;

    assign job_ready_o    = r_state == S_LOAD;
    assign w_hs           = job_valid_i & job_ready_o;
    assign w_word_last    = r_word == W_LAST;
    assign w_col_last     = r_col == C_LAST;
    assign w_row_last     = r_row == R_LAST;
    assign w_unit_last    = w_col_last & w_row_last;
    assign w_col_nxt      = w_col_last ? '0 : r_col + 1'b1;
    assign w_row_nxt      = w_col_last ? (w_row_last ? '0 : r_row + 1'b1) : r_row;
    assign writerow_o     = r_wrow;
    assign writecol_o     = r_wcol;
    assign readrow_o      = r_rrow;
    assign readcol_o      = r_rcol;
    assign farmdata_o     = r_fdata;
    assign farmdata_oe_o  = r_oe;
    assign result_valid_o = r_res_valid;
    assign result_data_o  = r_res_data;
    assign result_row_o   = r_res_row;
    assign result_col_o   = r_res_col;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = (w_hs && w_word_last && w_unit_last) ? S_WAIT : S_LOAD;
            // r_guard keeps the first WAIT cycle from trusting a busy flag the farm has not raised yet
            S_WAIT:   w_state_nxt = (r_guard && !farmbusy_i) ? S_RADDR : S_WAIT;
            S_RADDR:  w_state_nxt = S_RCAP;
            S_RCAP:   w_state_nxt = S_RESULT;
            S_RESULT: w_state_nxt = result_ready_i ? (w_unit_last ? S_LOAD : S_RADDR) : S_RESULT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_guard     <= 1'b0;
            r_wrow      <= '0;
            r_wcol      <= '0;
            r_rrow      <= '0;
            r_rcol      <= '0;
            r_fdata     <= '0;
            r_oe        <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_row   <= '0;
            r_res_col   <= '0;
        end else begin
            r_oe    <= w_hs;
            r_guard <= r_state == S_WAIT;
            if (w_hs) begin
                r_fdata <= job_data_i;
                r_wrow  <= r_row;
                r_wcol  <= r_col;
                r_word  <= w_word_last ? '0 : r_word + 1'b1;
                if (w_word_last) begin
                    r_col <= w_col_nxt;
                    r_row <= w_row_nxt;
                end
            end
            if (r_state == S_WAIT && w_state_nxt == S_RADDR) begin
                r_rrow <= r_row;
                r_rcol <= r_col;
            end
            if (r_state == S_RADDR) begin
                r_res_data <= farmdata_i;
                r_res_row  <= r_row;
                r_res_col  <= r_col;
            end
            if (r_state == S_RCAP) r_res_valid <= 1'b1;
            if (r_state == S_RESULT && result_ready_i) begin
                r_res_valid <= 1'b0;
                r_col       <= w_col_nxt;
                r_row       <= w_row_nxt;
                if (!w_unit_last) begin
                    r_rrow <= w_row_nxt;
                    r_rcol <= w_col_nxt;
                end
            end
        end
    end
endmodule
